// File: rtl/hpm_cntrs.sv
// Hardware performance monitor counters: cycle, instret and N_HPM event
// counters with half-width CSR read/write access, per-counter inhibit,
// sticky overflow flags and an overflow interrupt.
// The event pulse port is named "events" because "event" is a reserved word.
module hpm_cntrs #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64,
    parameter int unsigned N_HPM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire,
    input  logic [N_HPM-1:0]  events,
    input  logic [4:0]        rd_idx,
    input  logic              rd_hi,
    output logic [XLEN-1:0]   rd_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_idx,
    input  logic              wr_hi,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              inh_we,
    input  logic [31:0]       inh_wdata,
    output logic [31:0]       inh,
    input  logic              ovf_clr,
    input  logic [31:0]       ovf_clr_mask,
    output logic [31:0]       ovf,
    output logic              irq,
    input  logic [31:0]       ovf_ien
);

    localparam int unsigned N_CNT = 3 + N_HPM;
    localparam int unsigned HI_W  = CNT_W - XLEN;

    // Bit k set when index k holds a real counter (index 1 is never implemented).
    function automatic logic [31:0] impl_mask();
        logic [31:0] m;
        m    = '0;
        m[0] = 1'b1;
        m[2] = 1'b1;
        for (int unsigned i = 0; i < N_HPM; i++) begin
            m[3+i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [31:0] IMPL = impl_mask();

    logic [CNT_W-1:0]  cnt_q [N_CNT];
    logic [CNT_W-1:0]  cnt_d [N_CNT];
    logic [31:0]       inh_q, inh_d;
    logic [31:0]       ovf_q, ovf_d;
    logic [31:0]       wrap;
    logic [N_CNT-1:0]  inc;
    logic [CNT_W-1:0]  rd_sel;
    logic [2*XLEN-1:0] rd_ext;

    // Per-counter increment requests, gated by the registered inhibit bits.
    always_comb begin
        inc    = '0;
        inc[0] = 1'b1;
        inc[2] = retire;
        for (int unsigned i = 0; i < N_HPM; i++) begin
            inc[3+i] = events[i];
        end
        inc = inc & ~inh_q[N_CNT-1:0];
    end

    // Counter next state: a half write wins over an increment in the same cycle.
    always_comb begin
        wrap = '0;
        for (int unsigned k = 0; k < N_CNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (IMPL[k] && wr_en && (wr_idx == 5'(k))) begin
                if (wr_hi) begin
                    cnt_d[k][CNT_W-1:XLEN] = wr_data[HI_W-1:0];
                end else begin
                    cnt_d[k][XLEN-1:0] = wr_data;
                end
            end else if (IMPL[k] && inc[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
                wrap[k]  = &cnt_q[k];
            end
        end
    end

    // Sticky overflow (set beats clear) and inhibit register next state.
    always_comb begin
        ovf_d = ((ovf_q & ~(ovf_clr ? ovf_clr_mask : 32'h0)) | wrap) & IMPL;
        inh_d = inh_we ? (inh_wdata & IMPL) : inh_q;
    end

    // State registers with synchronous reset overriding all other updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_CNT; k++) begin
                cnt_q[k] <= '0;
            end
            inh_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int unsigned k = 0; k < N_CNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            inh_q <= inh_d;
            ovf_q <= ovf_d;
        end
    end

    // Zero-latency read mux; the upper half is zero-extended to XLEN.
    always_comb begin
        rd_sel = '0;
        for (int unsigned k = 0; k < N_CNT; k++) begin
            if (IMPL[k] && (rd_idx == 5'(k))) begin
                rd_sel = cnt_q[k];
            end
        end
        rd_ext            = '0;
        rd_ext[CNT_W-1:0] = rd_sel;
        rd_data           = rd_hi ? rd_ext[2*XLEN-1:XLEN] : rd_ext[XLEN-1:0];
    end

    assign inh = inh_q;
    assign ovf = ovf_q;
    assign irq = |(ovf_q & ovf_ien);

endmodule

// File: tb/tb_hpm_cntrs.sv
// Directed bench for hpm_cntrs: stimulus pushes expected values into a
// scoreboard queue, a separate monitor pops and compares against the DUT.
module tb_hpm_cntrs;

    localparam int K_RD  = 0;
    localparam int K_OVF = 1;
    localparam int K_INH = 2;
    localparam int K_IRQ = 3;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire;
    logic [3:0]  events;
    logic [4:0]  rd_idx;
    logic        rd_hi;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic        wr_hi;
    logic [31:0] wr_data;
    logic        inh_we;
    logic [31:0] inh_wdata;
    logic [31:0] inh;
    logic        ovf_clr;
    logic [31:0] ovf_clr_mask;
    logic [31:0] ovf;
    logic        irq;
    logic [31:0] ovf_ien;

    item_t q[$];
    event  chk_ev;
    int    n_vec  = 0;
    int    n_miss = 0;

    hpm_cntrs #(.XLEN(32), .CNT_W(64), .N_HPM(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .retire       (retire),
        .events       (events),
        .rd_idx       (rd_idx),
        .rd_hi        (rd_hi),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_hi        (wr_hi),
        .wr_data      (wr_data),
        .inh_we       (inh_we),
        .inh_wdata    (inh_wdata),
        .inh          (inh),
        .ovf_clr      (ovf_clr),
        .ovf_clr_mask (ovf_clr_mask),
        .ovf          (ovf),
        .irq          (irq),
        .ovf_ien      (ovf_ien)
    );

    always #50 clk = ~clk;

    // Watchdog: a run that never reaches the end is a failure.
    initial begin
        #1_000_000;
        $display("FAIL timeout: test did not complete");
        $fatal(1, "watchdog expired");
    end

    // Monitor: drain the scoreboard each time the stimulus presents a sample.
    initial begin
        item_t       it;
        logic [63:0] act;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                it = q.pop_front();
                case (it.kind)
                    K_RD:    act = 64'(rd_data);
                    K_OVF:   act = 64'(ovf);
                    K_INH:   act = 64'(inh);
                    default: act = 64'(irq);
                endcase
                n_vec++;
                if (act !== it.exp) begin
                    n_miss++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic check(input logic [63:0] act, input logic [63:0] e, input string name);
        n_vec++;
        if (act !== e) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input logic [4:0] idx, input logic hi, input logic [31:0] e,
                          input string name);
        item_t it;
        rd_idx = idx;
        rd_hi  = hi;
        #1;
        it = '{K_RD, 64'(e), name};
        q.push_back(it);
        -> chk_ev;
        #1;
    endtask

    task automatic exp_sig(input int kind, input logic [31:0] e, input string name);
        item_t it;
        #1;
        it = '{kind, 64'(e), name};
        q.push_back(it);
        -> chk_ev;
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic hi, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_hi   = hi;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; retire = 1'b0; events = '0; rd_idx = '0; rd_hi = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_hi = 1'b0; wr_data = '0;
        inh_we = 1'b0; inh_wdata = '0; ovf_clr = 1'b0; ovf_clr_mask = '0; ovf_ien = '0;

        // Reset for three edges, then check everything reads zero.
        repeat (3) step();
        rst = 1'b0;
        check(64'(ovf), 64'h0, "rst_ovf_direct");
        check(64'(inh), 64'h0, "rst_inh_direct");
        check(64'(irq), 64'h0, "rst_irq_direct");
        rd_idx = 5'd0; rd_hi = 1'b0;
        #1;
        check(64'(rd_data), 64'h0, "rst_cycle_lo_direct");
        exp_rd(0, 0, 32'h0, "rst_cycle_lo");
        exp_rd(0, 1, 32'h0, "rst_cycle_hi");
        exp_rd(2, 0, 32'h0, "rst_instret");
        exp_rd(3, 0, 32'h0, "rst_ev0");
        exp_rd(1, 0, 32'h0, "rst_idx1");
        exp_rd(31, 0, 32'h0, "rst_idx31");
        exp_sig(K_OVF, 32'h0, "rst_ovf");
        exp_sig(K_INH, 32'h0, "rst_inh");
        exp_sig(K_IRQ, 32'h0, "rst_irq");

        // Ten free-running cycles, no retire.
        repeat (10) step();
        exp_rd(0, 0, 32'd10, "cycle_10");
        exp_rd(0, 1, 32'h0, "cycle_10_hi");
        exp_rd(2, 0, 32'h0, "instret_idle");

        // Carry across halves; the write cycle itself drops the increment.
        wr(0, 0, 32'hFFFF_FFFF);
        exp_rd(0, 0, 32'hFFFF_FFFF, "cycle_wr_lo");
        exp_rd(0, 1, 32'h0, "cycle_wr_hi");
        step();
        exp_rd(0, 1, 32'h1, "cycle_carry_hi");
        exp_rd(0, 0, 32'h0, "cycle_carry_lo");
        exp_sig(K_OVF, 32'h0, "no_ovf_on_carry");

        // Event 0 wrap sets ovf[3]; writes alone never set it.
        wr(3, 0, 32'hFFFF_FFFF);
        wr(3, 1, 32'hFFFF_FFFF);
        exp_rd(3, 0, 32'hFFFF_FFFF, "ev0_ones_lo");
        exp_rd(3, 1, 32'hFFFF_FFFF, "ev0_ones_hi");
        exp_sig(K_OVF, 32'h0, "ovf_not_from_write");
        events = 4'b0001;
        step();
        events = '0;
        exp_rd(3, 0, 32'h0, "ev0_wrap_lo");
        exp_rd(3, 1, 32'h0, "ev0_wrap_hi");
        exp_sig(K_OVF, 32'h8, "ovf3_set");
        exp_sig(K_IRQ, 32'h0, "irq_masked");
        ovf_ien = 32'h8;
        exp_sig(K_IRQ, 32'h1, "irq_enabled");
        ovf_clr = 1'b1; ovf_clr_mask = 32'h8;
        step();
        ovf_clr = 1'b0;
        exp_sig(K_OVF, 32'h0, "ovf3_cleared");
        exp_sig(K_IRQ, 32'h0, "irq_cleared");

        // Wrap and clear in the same cycle: set wins.
        wr(3, 0, 32'hFFFF_FFFF);
        wr(3, 1, 32'hFFFF_FFFF);
        events = 4'b0001; ovf_clr = 1'b1;
        step();
        events = '0; ovf_clr = 1'b0;
        exp_sig(K_OVF, 32'h8, "set_beats_clear");
        exp_sig(K_IRQ, 32'h1, "irq_set_beats_clear");
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        exp_sig(K_OVF, 32'h0, "ovf3_cleared2");

        // Inhibit: the write edge still counts with the old inhibit value.
        inh_we = 1'b1; inh_wdata = 32'hFFFF_FFFF; retire = 1'b1;
        step();
        inh_we = 1'b0;
        exp_sig(K_INH, 32'h0000_007D, "inh_masked");
        exp_rd(2, 0, 32'h1, "instret_before_inh");
        repeat (5) step();
        exp_rd(2, 0, 32'h1, "instret_inhibited");
        inh_we = 1'b1; inh_wdata = 32'h0;
        step();
        inh_we = 1'b0;
        exp_sig(K_INH, 32'h0, "inh_cleared");
        exp_rd(2, 0, 32'h1, "instret_inh_edge");
        repeat (2) step();
        retire = 1'b0;
        exp_rd(2, 0, 32'h3, "instret_plus2");

        // Writes to unimplemented indices are ignored.
        wr(1, 0, 32'hDEAD_BEEF);
        exp_rd(1, 0, 32'h0, "idx1_ignored");
        wr(31, 1, 32'hDEAD_BEEF);
        exp_rd(31, 1, 32'h0, "idx31_ignored");

        // Write and retire together: the write wins.
        wr_en = 1'b1; wr_idx = 5'd2; wr_hi = 1'b0; wr_data = 32'h100; retire = 1'b1;
        step();
        wr_en = 1'b0; retire = 1'b0;
        exp_rd(2, 0, 32'h100, "instret_wr_wins");
        exp_rd(2, 1, 32'h0, "instret_wr_hi");

        // Build up ovf and inh, then reset with everything active.
        wr(4, 0, 32'hFFFF_FFFF);
        wr(4, 1, 32'hFFFF_FFFF);
        events = 4'b0010;
        step();
        events = '0;
        exp_sig(K_OVF, 32'h10, "ovf4_set");
        exp_sig(K_IRQ, 32'h0, "irq_ovf4_masked");
        inh_we = 1'b1; inh_wdata = 32'h4;
        step();
        inh_we = 1'b0;
        exp_sig(K_INH, 32'h4, "inh_bit2");
        rst = 1'b1; wr_en = 1'b1; wr_idx = 5'd0; wr_hi = 1'b0; wr_data = 32'h5;
        events = 4'hF; retire = 1'b1; inh_we = 1'b1; inh_wdata = 32'hFF;
        step();
        rst = 1'b0; wr_en = 1'b0; events = '0; retire = 1'b0; inh_we = 1'b0;
        check(64'(ovf), 64'h0, "mid_rst_ovf_direct");
        check(64'(inh), 64'h0, "mid_rst_inh_direct");
        exp_rd(0, 0, 32'h0, "mid_rst_cycle_lo");
        exp_rd(0, 1, 32'h0, "mid_rst_cycle_hi");
        exp_rd(2, 0, 32'h0, "mid_rst_instret");
        for (int i = 3; i < 7; i++) begin
            exp_rd(5'(i), 0, 32'h0, $sformatf("mid_rst_ev%0d", i - 3));
        end
        exp_rd(4, 1, 32'h0, "mid_rst_ev1_hi");
        exp_rd(1, 0, 32'h0, "mid_rst_idx1");
        exp_rd(31, 0, 32'h0, "mid_rst_idx31");
        exp_sig(K_OVF, 32'h0, "mid_rst_ovf");
        exp_sig(K_INH, 32'h0, "mid_rst_inh");
        exp_sig(K_IRQ, 32'h0, "mid_rst_irq");

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        if (n_miss != 0) begin
            $display("FAIL: %0d miscompares", n_miss);
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule
